// File: rtl/inv_cipher_if.sv
// Request/response bundle between a requester and the AES-128 decryption core,
// plus the round-key lookup port and the core's FSM state for observation.
interface inv_cipher_if;
  // Handshake: the core is ready exactly when busy == 0. A request is accepted
  // on a rising edge where start == 1 and busy == 0, and ciphertext is captured
  // on that edge. done pulses for one cycle when plaintext takes a new value.
  // round_key must reflect key_idx combinationally in every cycle.
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] round_key;
  logic [3:0]   key_idx;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;
  logic [1:0]   fsm_state;

  modport master (
    output start, ciphertext, round_key,
    input  key_idx, busy, done, plaintext, fsm_state
  );

  modport slave (
    input  start, ciphertext, round_key,
    output key_idx, busy, done, plaintext, fsm_state
  );
endinterface

// File: rtl/inv_cipher_core.sv
// Iterative AES-128 decryption: one FIPS-197 InvCipher round per clock,
// round keys fetched one per cycle through the key_idx/round_key port.
module inv_cipher_core (
  input  logic       clk,
  input  logic       rst,
  inv_cipher_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_t;

  // Entry for byte value b sits at bits [8*(255-b) +: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sub(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sub(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r of the column-major state rotates right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = xt(a[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  state_t       state, state_nxt;
  logic [127:0] state_reg;
  logic [3:0]   rcnt;
  logic [127:0] pt_reg;
  logic         done_reg;
  logic [3:0]   key_idx_c;
  logic         busy_c;
  logic [127:0] ark;
  logic [127:0] round_out;

  // Shared front half of ROUND and FINAL; FINAL skips InvMixColumns.
  assign ark       = inv_sub_bytes(inv_shift_rows(state_reg)) ^ bus.round_key;
  assign round_out = inv_mix_columns(ark);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_idx_c = 4'd10;
    busy_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = ROUND;
      end
      ROUND: begin
        key_idx_c = rcnt;
        busy_c    = 1'b1;
        if (rcnt == 4'd1) state_nxt = FINAL;
      end
      FINAL: begin
        key_idx_c = 4'd0;
        busy_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      rcnt      <= 4'd0;
      pt_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_reg <= bus.ciphertext ^ bus.round_key;
            rcnt      <= 4'd9;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          if (rcnt != 4'd1) rcnt <= rcnt - 4'd1;
        end
        FINAL: begin
          pt_reg   <= ark;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.key_idx   = key_idx_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_reg;
  assign bus.plaintext = pt_reg;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_inv_cipher_core.sv
// Directed and random checks of inv_cipher_core against a forward-cipher model:
// the bench encrypts with its own arithmetic S-box and expects the core to invert it.
module tb_inv_cipher_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_cipher_if bus ();

  inv_cipher_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]   sbox [256];
  logic [127:0] rk [11];
  logic [127:0] last_pt;
  int total = 0;
  int bad   = 0;

  // Key store model: combinational lookup of the schedule by key_idx.
  assign bus.round_key = (bus.key_idx <= 4'd10) ? rk[bus.key_idx] : 128'h0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[i] = s;
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] pb(input logic [127:0] s, input int i, input logic [7:0] v);
    s[127-8*i -: 8] = v;
    return s;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp  = {tmp[23:0], tmp[31:24]};
        tmp  = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp  = tmp ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t = pb(t, r + 4*c, sbox[gb(s, r + 4*((c + r) % 4))]);
      s = t;
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
          s = pb(s, 4*c,   gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3);
          s = pb(s, 4*c+1, a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3);
          s = pb(s, 4*c+2, a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03));
          s = pb(s, 4*c+3, gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02));
        end
      end
      s = s ^ rk[rnd];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has set start/ciphertext; the next edge is the accept edge.
  // Returns while sampling cycle T11 (done cycle).
  task automatic run_block(input logic [127:0] exp_pt, input bit keep_start,
                           input bit poke, input string name);
    logic [3:0] exp_idx;
    check($sformatf("%s_t0_busy", name), bus.busy, 0);
    check($sformatf("%s_t0_idx", name), bus.key_idx, 10);
    for (int t = 1; t <= 11; t++) begin
      step();
      exp_idx = (t <= 9) ? 4'(10 - t) : ((t == 10) ? 4'd0 : 4'd10);
      if (t == 11) last_pt = exp_pt;
      check($sformatf("%s_t%0d_idx", name, t), bus.key_idx, exp_idx);
      check($sformatf("%s_t%0d_busy", name, t), bus.busy, (t <= 10));
      check($sformatf("%s_t%0d_done", name, t), bus.done, (t == 11));
      check($sformatf("%s_t%0d_pt", name, t), bus.plaintext, last_pt);
      if (t == 1) begin
        bus.ciphertext = rand128();
        if (!keep_start) bus.start = 1'b0;
      end
      if (poke && (t == 3 || t == 7)) begin
        bus.start      = 1'b1;
        bus.ciphertext = rand128();
      end else if (poke && (t == 4 || t == 8)) begin
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key, pt;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.ciphertext = '0;
    last_pt        = '0;
    build_sbox();
    load_key(C1_KEY);
    step();
    step();
    check("rst_idx", bus.key_idx, 10);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pt", bus.plaintext, 0);
    rst = 1'b0;
    step();

    // FIPS-197 C.1
    bus.start = 1'b1; bus.ciphertext = C1_CT;
    run_block(C1_PT, 0, 0, "c1");
    step(); check("c1_after_done", bus.done, 0);

    // FIPS-197 appendix B
    load_key(B_KEY);
    bus.start = 1'b1; bus.ciphertext = B_CT;
    run_block(B_PT, 0, 0, "fipsb");
    step(); check("fipsb_after_done", bus.done, 0);

    // start pulses while busy must be ignored
    load_key(C1_KEY);
    bus.start = 1'b1; bus.ciphertext = C1_CT;
    run_block(C1_PT, 0, 1, "busyrej");
    step(); check("busyrej_after_done", bus.done, 0);
    check("busyrej_after_busy", bus.busy, 0);

    // back-to-back with start held high
    bus.start = 1'b1; bus.ciphertext = C1_CT;
    run_block(C1_PT, 1, 0, "b2b_a");
    bus.ciphertext = B_CT;
    load_key(B_KEY);
    run_block(B_PT, 0, 0, "b2b_b");
    step(); check("b2b_after_done", bus.done, 0);

    // reset in cycle T5
    load_key(C1_KEY);
    bus.start = 1'b1; bus.ciphertext = C1_CT;
    for (int t = 1; t <= 5; t++) begin
      step();
      bus.start = 1'b0;
      check($sformatf("midrst_t%0d_busy", t), bus.busy, 1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_pt = '0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_pt", bus.plaintext, 0);
    check("midrst_idx", bus.key_idx, 10);
    for (int t = 0; t < 12; t++) begin
      step();
      check($sformatf("midrst_quiet%0d_done", t), bus.done, 0);
      check($sformatf("midrst_quiet%0d_busy", t), bus.busy, 0);
    end
    bus.start = 1'b1; bus.ciphertext = C1_CT;
    run_block(C1_PT, 0, 0, "midrst_fresh");
    step();

    // reset and start together: reset wins
    rst = 1'b1; bus.start = 1'b1; bus.ciphertext = B_CT;
    step();
    rst = 1'b0; bus.start = 1'b0;
    last_pt = '0;
    check("rstprio_busy", bus.busy, 0);
    check("rstprio_idx", bus.key_idx, 10);
    check("rstprio_pt", bus.plaintext, 0);
    for (int t = 0; t < 12; t++) begin
      step();
      check($sformatf("rstprio_quiet%0d_busy", t), bus.busy, 0);
      check($sformatf("rstprio_quiet%0d_done", t), bus.done, 0);
    end

    // random keys and plaintexts, ciphertext from the forward model
    for (int n = 0; n < 8; n++) begin
      key = rand128();
      pt  = rand128();
      load_key(key);
      bus.start = 1'b1; bus.ciphertext = encrypt(pt);
      run_block(pt, 0, 0, $sformatf("rnd%0d", n));
      step(); check($sformatf("rnd%0d_after_done", n), bus.done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
